// File: rtl/rv32i_run_pkg.sv
// Shared types for the RV32I run controller: FSM states, run result codes
// and the trace entry layout.
package rv32i_run_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RESET = 2'b01,
        RUN   = 2'b10,
        DONE  = 2'b11
    } run_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        HALTED  = 2'b01,
        TIMEOUT = 2'b10
    } run_status_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/rv32i_trace_fifo.sv
// Trace FIFO with a registered head, occupancy count and sticky overflow.
// A synchronous clear empties it and drops the overflow flag.
module rv32i_trace_fifo
    import rv32i_run_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 2 * XLEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    // Next-state for pointers, occupancy, flags and the registered head.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) count_d = count_q + CNTW'(1);
        if (do_pop && !do_push) count_d = count_q - CNTW'(1);
        if (push && !do_push)   ovf_d   = 1'b1;

        // An entry written into the slot the head is about to point at must bypass memory.
        if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
        else                                   head_d = mem_q[rd_ptr_d];

        if (clr) begin
            do_pop   = 1'b0;
            do_push  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            head_d   = head_q;
        end

        full_d  = (count_d == CNTW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy decides validity, so it can map to RAM.
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata    = head_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/rv32i_run_ctrl.sv
// Run controller for the RV32I core: sequences core reset, counts RUN
// cycles against a budget, detects a PC self-loop halt and buffers the
// writeback trace for readout.
module rv32i_run_ctrl
    import rv32i_run_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 1024,
    parameter int unsigned HALT_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [XLEN-1:0]                 pc_in,
    input  logic [XLEN-1:0]                 wb_in,
    input  logic                            wb_valid,
    output logic                            core_rst,
    output logic                            running,
    output logic                            trc_valid,
    input  logic                            trc_ready,
    output logic [XLEN-1:0]                 trc_pc,
    output logic [XLEN-1:0]                 trc_data,
    output logic [$clog2(DEPTH):0]          trc_count,
    output logic                            overflow,
    output logic                            done,
    output logic [1:0]                      status,
    output logic [$clog2(MAX_CYCLES+1)-1:0] cycles
);

    localparam int unsigned CW  = $clog2(MAX_CYCLES + 1);
    localparam int unsigned HW  = $clog2(HALT_CYCLES + 1);
    localparam int unsigned RCW = $clog2(RST_CYCLES + 1);

    run_state_e       state_q, state_d;
    run_status_e      status_q, status_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]    cycles_q, cycles_d;
    logic [HW-1:0]    halt_cnt_q, halt_cnt_d;
    logic [XLEN-1:0]  pc_prev_q, pc_prev_d;
    logic             first_q, first_d;
    logic             core_rst_q, core_rst_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             fifo_clr, fifo_push, fifo_empty;
    logic [2*XLEN-1:0] fifo_head;

    // FSM next state, cycle budget, halt detection and registered outputs.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        rst_cnt_d  = rst_cnt_q;
        cycles_d   = cycles_q;
        halt_cnt_d = halt_cnt_q;
        pc_prev_d  = pc_prev_q;
        first_d    = first_q;
        fifo_clr   = 1'b0;
        fifo_push  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RESET;
                    status_d   = NONE;
                    rst_cnt_d  = '0;
                    cycles_d   = '0;
                    halt_cnt_d = '0;
                    first_d    = 1'b1;
                    fifo_clr   = 1'b1;
                end
            end
            RESET: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) state_d = RUN;
                else                                   rst_cnt_d = rst_cnt_q + RCW'(1);
            end
            RUN: begin
                fifo_push = wb_valid;
                cycles_d  = cycles_q + CW'(1);
                pc_prev_d = pc_in;
                first_d   = 1'b0;
                // The first RUN cycle has no previous PC, so it always counts as a change.
                if (!first_q && (pc_in == pc_prev_q)) halt_cnt_d = halt_cnt_q + HW'(1);
                else                                  halt_cnt_d = '0;

                if (halt_cnt_d == HW'(HALT_CYCLES)) begin
                    status_d = HALTED;
                    state_d  = DONE;
                end else if (cycles_d == CW'(MAX_CYCLES)) begin
                    status_d = TIMEOUT;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        core_rst_d = (state_d != RUN);
        running_d  = (state_d == RUN);
        done_d     = (state_d == DONE);
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            status_q   <= NONE;
            rst_cnt_q  <= '0;
            cycles_q   <= '0;
            halt_cnt_q <= '0;
            pc_prev_q  <= '0;
            first_q    <= 1'b1;
            core_rst_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            rst_cnt_q  <= rst_cnt_d;
            cycles_q   <= cycles_d;
            halt_cnt_q <= halt_cnt_d;
            pc_prev_q  <= pc_prev_d;
            first_q    <= first_d;
            core_rst_q <= core_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    rv32i_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_trace_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (fifo_clr),
        .push     (fifo_push),
        .pop      (trc_ready),
        .wdata    ({pc_in, wb_in}),
        .rdata    (fifo_head),
        .empty    (fifo_empty),
        .count    (trc_count),
        .overflow (overflow)
    );

    assign core_rst  = core_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign status    = status_q;
    assign cycles    = cycles_q;
    assign trc_valid = !fifo_empty;
    assign trc_pc    = fifo_head[2*XLEN-1:XLEN];
    assign trc_data  = fifo_head[XLEN-1:0];

endmodule

// File: doc/rv32i_run_ctrl.md
# rv32i_run_ctrl

Parametrised run controller for the RV32I core: it sequences the core reset, counts executed cycles against a budget, detects a halted core (PC self-loop), and buffers a writeback trace in a FIFO for readout. It sits between the platform clock/reset and `rv32i_top`. It is the synthesizable successor to the fixed clock/reset stimulus used in simulation, so the same run control works in simulation and on the board.

## Interface
Clock `clk`, reset `rst`; reset is asynchronous and active-high.

Parameters:
- `XLEN`, 32: width of the PC and writeback data.
- `DEPTH`, 16: trace FIFO entries; must be a power of two and at least 2.
- `RST_CYCLES`, 2: number of cycles `core_rst` is held during a run start; must be at least 1.
- `MAX_CYCLES`, 1024: cycle budget before a timeout.
- `HALT_CYCLES`, 4: number of consecutive cycles with an unchanged PC that counts as a halt; must be at least 1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: start-run request; sampled in IDLE and DONE.
- `pc_in` in XLEN: core PC.
- `wb_in` in XLEN: core writeback value.
- `wb_valid` in 1: writeback qualifier.
- `core_rst` out 1: active-high reset to the core.
- `running` out 1: high in RUN.
- `trc_valid` out 1: FIFO not empty.
- `trc_ready` in 1: consumer pop.
- `trc_pc` out XLEN: FIFO head PC.
- `trc_data` out XLEN: FIFO head writeback value.
- `trc_count` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` out 1: sticky; a push was dropped.
- `done` out 1: high in DONE.
- `status` out 2: run result; 00 none, 01 halted, 10 timeout.
- `cycles` out $clog2(MAX_CYCLES+1): RUN cycle count.

## Operation
FSM states: IDLE, RESET, RUN, DONE.
- **IDLE**
  - `core_rst`=1.
  - `start` moves to RESET.
- **RESET**
  - `core_rst`=1 for exactly RST_CYCLES cycles, then the FSM moves to RUN.
  - Entering RESET clears the FIFO, `overflow`, `status`, `cycles`, and the halt counter.
- **RUN**
  - `core_rst`=0.
  - `cycles` increments every cycle.
  - Halt counter:
    - increments when `pc_in` equals the PC registered on the previous cycle;
    - otherwise clears to 0;
    - the first RUN cycle has no previous PC and counts as a change.
  - Halt counter reaching HALT_CYCLES: `status`=01, go to DONE.
  - Otherwise, `cycles` reaching MAX_CYCLES: `status`=10, go to DONE.
  - Halt and timeout in the same cycle: halt wins.
- **DONE**
  - `core_rst`=1, so the core is frozen in reset.
  - `status` and `cycles` are held.
  - FIFO stays readable.
  - `start` moves to RESET, which clears the previous trace.
- Trace FIFO:
  - Push happens only in RUN with `wb_valid`=1; the entry is {`pc_in`, `wb_in`}.
  - Pop happens when `trc_valid` and `trc_ready`, in any state.
  - Push when full with no pop: entry dropped, `overflow` set.
  - Push and pop in the same cycle when full: both occur, occupancy unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only; the entry becomes visible on the next cycle.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset values (on `rst`):
  - FSM=IDLE, `core_rst`=1, `running`=0, `done`=0.
  - `trc_valid`=0, `trc_count`=0, `overflow`=0, `status`=00, `cycles`=0.
  - `trc_pc`/`trc_data` are don't-care while `trc_valid`=0.
- `rst` asserted mid-run: returns to IDLE immediately (asynchronous) and clears all state.

## Timing
- All outputs are registered. `trc_pc`/`trc_data` show the FIFO head registered on the last write or pop.
- Run start:
  - `start` sampled at edge N puts the FSM in RESET.
  - `core_rst` falls after edge N+RST_CYCLES.
  - `running` rises in the same cycle `core_rst` falls.
- Push to visible: a push sampled at edge N gives `trc_valid`=1 after edge N.
- Halt detection:
  - If the PC first repeats in the cycle after edge M, then `done`=1 after edge M+HALT_CYCLES.
  - `running` and `done` are never both high.
- Timeout: `done` rises after exactly MAX_CYCLES cycles in RUN; `cycles`=MAX_CYCLES.

## Structure
- Package `rv32i_run_pkg`:
  - `run_state_e` enum (IDLE/RESET/RUN/DONE);
  - `run_status_e` (NONE=2'b00, HALTED=2'b01, TIMEOUT=2'b10);
  - `trace_entry_t` struct {pc, data}, parametrised by XLEN through a localparam default of 32.
- Sub-module `rv32i_trace_fifo`:
  - parameters DEPTH and width;
  - synchronous clear input;
  - push, pop, full, empty, count, and overflow flag.
- The FSM, cycle counter, and halt detector live in `rv32i_run_ctrl`.

## Test plan
- **Reset/start sequence:** `rst` pulse, then `start` for one cycle with RST_CYCLES=2 → `core_rst` held 2 cycles after start is sampled, then `running`=1; all outputs at reset values before `start`.
- **Halt:** PC stream 0x0, 0x4, 0x8, then 0x8 held, HALT_CYCLES=4 → `done`=1, `status`=01, `cycles`=7, `core_rst`=1.
- **Timeout:** MAX_CYCLES=20 with an incrementing PC → `done` after 20 RUN cycles, `status`=10, `cycles`=20.
- **FIFO capacity:** DEPTH=4, `trc_ready`=0, 6 writebacks 0xA0..0xA5 → `trc_count`=4, `overflow`=1; draining then yields 0xA0..0xA3 in order with matching PCs.
- **Full push/pop:** full FIFO with simultaneous push and pop → count stays 4, `overflow`=0, head advances by one.
- **Reset mid-run and rerun:**
  - `rst` asserted mid-RUN → FSM=IDLE and FIFO empty immediately.
  - `start` in DONE → trace and `status` cleared before the new run.
